// File: rtl/vld_demux5_reg.sv
// One-entry registered 1:5 valid/ready demux with a shared payload.
// Words with an out-of-range index are dropped and counted.
module vld_demux5_reg #(
  parameter int DW = 1
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          in_vld,
  input  logic [2:0]    in_sel,
  input  logic [DW-1:0] in_data,
  output logic          in_rdy,
  output logic [4:0]    out_vld,
  input  logic [4:0]    out_rdy,
  output logic [DW-1:0] out_data,
  output logic          err_o,
  output logic [7:0]    err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_data;
  logic [2:0]    r_dst;
  logic          r_err;
  logic [7:0]    r_cnt;

  logic          w_dst_rdy;
  logic          w_drain;
  logic          w_acc;
  logic          w_legal;
  logic          w_load;
  logic          w_drop;
  logic [4:0]    w_onehot;

  always_comb begin
    w_dst_rdy = 1'b0;
    case (r_dst)
      3'd0:    w_dst_rdy = out_rdy[0];
      3'd1:    w_dst_rdy = out_rdy[1];
      3'd2:    w_dst_rdy = out_rdy[2];
      3'd3:    w_dst_rdy = out_rdy[3];
      3'd4:    w_dst_rdy = out_rdy[4];
      default: w_dst_rdy = 1'b0;
    endcase
  end

  always_comb begin
    w_onehot = 5'b0;
    case (r_dst)
      3'd0:    w_onehot = 5'b00001;
      3'd1:    w_onehot = 5'b00010;
      3'd2:    w_onehot = 5'b00100;
      3'd3:    w_onehot = 5'b01000;
      3'd4:    w_onehot = 5'b10000;
      default: w_onehot = 5'b0;
    endcase
  end

  assign w_drain = (r_state == FULL) & w_dst_rdy;
  assign in_rdy  = (r_state == EMPTY) | w_drain;
  assign w_acc   = in_vld & in_rdy;
  assign w_legal = (in_sel <= 3'd4);
  assign w_load  = w_acc & w_legal;
  assign w_drop  = w_acc & ~w_legal;

  // a legal load wins over a drain, keeping FULL for back-to-back words
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = FULL;
    end else if (w_drain) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_data <= '0;
      r_dst  <= 3'd0;
    end else if (w_load) begin
      r_data <= in_data;
      r_dst  <= in_sel;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_err <= 1'b0;
      r_cnt <= 8'd0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign out_vld  = (r_state == FULL) ? w_onehot : 5'b0;
  assign out_data = r_data;
  assign err_o    = r_err;
  assign err_cnt  = r_cnt;

endmodule

// File: tb/tb_vld_demux5_reg.sv
// Scoreboard bench for vld_demux5_reg: stimulus pushes expectations,
// a negedge monitor pops them on every drain and every error pulse.
module tb_vld_demux5_reg;

  localparam int DW = 8;

  logic          hclk;
  logic          hresetn;
  logic          in_vld;
  logic [2:0]    in_sel;
  logic [DW-1:0] in_data;
  logic          in_rdy;
  logic [4:0]    out_vld;
  logic [4:0]    out_rdy;
  logic [DW-1:0] out_data;
  logic          err_o;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;

  logic [12:0] q_word[$];
  logic [7:0]  q_err[$];
  logic [7:0]  m_cnt;

  vld_demux5_reg #(.DW(DW)) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .in_vld   (in_vld),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .err_o    (err_o),
    .err_cnt  (err_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // waits for in_rdy, records the expectation, then lets the edge accept
  task automatic send(input logic [2:0] sel, input logic [7:0] d,
                      output int waits);
    logic [4:0] oh;
    waits = 0;
    in_vld  = 1'b1;
    in_sel  = sel;
    in_data = d;
    @(negedge hclk);
    while (!in_rdy && waits < 50) begin
      waits++;
      @(negedge hclk);
    end
    if (!in_rdy) begin
      chk("send_timeout", 32'(waits), 32'd0);
    end else if (sel <= 3'd4) begin
      oh = 5'b00001 << sel;
      q_word.push_back({oh, d});
    end else begin
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      q_err.push_back(m_cnt);
    end
    @(posedge hclk);
    #1;
    in_vld = 1'b0;
  endtask

  always @(negedge hclk) begin
    logic [12:0] e;
    if (out_vld != 5'b0 && (out_vld & out_rdy) != 5'b0) begin
      if (q_word.size() == 0) begin
        chk("mon_unexpected_word", {19'd0, out_vld, out_data}, 32'd0);
      end else begin
        e = q_word.pop_front();
        chk("mon_out_vld", 32'(out_vld), 32'(e[12:8]));
        chk("mon_out_data", 32'(out_data), 32'(e[7:0]));
      end
    end
    if (err_o === 1'b1) begin
      if (q_err.size() == 0) begin
        chk("mon_unexpected_err", 32'(err_o), 32'd0);
      end else begin
        chk("mon_err_cnt", 32'(err_cnt), 32'(q_err.pop_front()));
      end
    end
  end

  initial begin
    int w;
    hresetn = 1'b0;
    in_vld  = 1'b0;
    in_sel  = 3'd0;
    in_data = '0;
    out_rdy = 5'b11111;
    m_cnt   = 8'd0;
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    @(negedge hclk);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_err_o", 32'(err_o), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge hclk);
    #1;

    // single transfer
    send(3'd3, 8'hA5, w);
    @(negedge hclk);
    chk("single_vld", 32'(out_vld), 32'h08);
    chk("single_data", 32'(out_data), 32'hA5);
    @(negedge hclk);
    chk("single_empty", 32'(out_vld), 32'd0);
    @(posedge hclk);
    #1;

    // backpressure on destination 1, other readies ignored
    out_rdy = 5'b11101;
    send(3'd1, 8'h11, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      chk("bp_vld", 32'(out_vld), 32'h02);
      chk("bp_data", 32'(out_data), 32'h11);
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
    end
    @(posedge hclk);
    #1;
    out_rdy = 5'b11111;
    @(negedge hclk);
    chk("bp_drain_rdy", 32'(in_rdy), 32'd1);
    @(negedge hclk);
    chk("bp_after_vld", 32'(out_vld), 32'd0);
    @(posedge hclk);
    #1;

    // streaming one word per cycle
    for (int s = 0; s < 5; s++) begin
      send(3'(s), 8'h20 + 8'(s), w);
      chk("stream_no_stall", 32'(w), 32'd0);
    end
    @(negedge hclk);
    chk("stream_last_vld", 32'(out_vld), 32'h10);
    @(negedge hclk);
    chk("stream_done", 32'(out_vld), 32'd0);
    @(posedge hclk);
    #1;

    // illegal index and counter saturation
    send(3'd6, 8'hEE, w);
    @(negedge hclk);
    chk("ill_vld", 32'(out_vld), 32'd0);
    chk("ill_err_o", 32'(err_o), 32'd1);
    chk("ill_err_cnt", 32'(err_cnt), 32'd1);
    chk("ill_data_kept", 32'(out_data), 32'h24);
    @(negedge hclk);
    chk("ill_err_o_low", 32'(err_o), 32'd0);
    @(posedge hclk);
    #1;
    for (int k = 0; k < 299; k++) begin
      send(3'(5 + (k % 3)), 8'(k), w);
    end
    @(negedge hclk);
    chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
    chk("sat_vld", 32'(out_vld), 32'd0);
    @(posedge hclk);
    #1;

    // reset while holding a word for destination 2
    out_rdy = 5'b00000;
    send(3'd2, 8'h55, w);
    @(negedge hclk);
    chk("pre_rst_vld", 32'(out_vld), 32'h04);
    @(posedge hclk);
    #1;
    hresetn = 1'b0;
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    q_word.delete();
    m_cnt = 8'd0;
    @(negedge hclk);
    chk("mid_rst_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_rdy", 32'(in_rdy), 32'd1);
    @(posedge hclk);
    #1;

    // illegal accept in the same cycle as a drain empties the block
    send(3'd4, 8'h77, w);
    out_rdy = 5'b10000;
    send(3'd7, 8'h99, w);
    chk("drain_ill_no_stall", 32'(w), 32'd0);
    @(negedge hclk);
    chk("drain_ill_vld", 32'(out_vld), 32'd0);
    chk("drain_ill_err", 32'(err_o), 32'd1);
    chk("drain_ill_cnt", 32'(err_cnt), 32'd1);
    chk("drain_ill_data", 32'(out_data), 32'h77);

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("sb_words_left", 32'(q_word.size()), 32'd0);
    chk("sb_errs_left", 32'(q_err.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vld_demux5_reg.md
VLD_DEMUX5_REG -- requirements
Module: vld_demux5_reg

Interface
REQ-001 SHALL provide parameter: DW, default 1, payload width in bits.
REQ-002 SHALL provide port: hclk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: hresetn  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port: in_vld  input  1  upstream word valid.
REQ-005 SHALL provide port: in_sel  input  3  binary destination index; legal values 0..4.
REQ-006 SHALL provide port: in_data  input  DW  upstream payload.
REQ-007 SHALL provide port: in_rdy  output  1  block can accept a word this cycle.
REQ-008 SHALL provide port: out_vld  output  5  one-hot valid; bit i means destination i.
REQ-009 SHALL provide port: out_rdy  input  5  per-destination ready; bit i belongs to destination i.
REQ-010 SHALL provide port: out_data  output  DW  payload shared by all five destinations.
REQ-011 SHALL provide port: err_o  output  1  one-cycle pulse; an illegal-index word was dropped.
REQ-012 SHALL provide port: err_cnt  output  8  saturating count of dropped words.

Function
REQ-013 SHALL implement a one-entry registered 1:5 demux with states EMPTY and FULL, plus registers data_q[DW], dst_q[3], err_q, cnt_q[8].
REQ-014 SHALL drive in_rdy = (state==EMPTY) | (state==FULL & out_rdy[dst_q]), combinationally.
REQ-015 SHALL accept a word when in_vld & in_rdy; in_sel and in_data are sampled in the same cycle.
REQ-016 SHALL, on accept with in_sel<=4, load data_q<=in_data and dst_q<=in_sel, and be FULL next cycle; latency is exactly 1 cycle.
REQ-017 SHALL drive out_vld = one-hot(dst_q) when FULL and 5'b0 when EMPTY; never more than one bit set.
REQ-018 SHALL drive out_data = data_q at all times; data_q holds its value while no new word loads.
REQ-019 SHALL complete a drain when FULL & out_rdy[dst_q]; out_rdy bits for non-selected destinations are ignored.
REQ-020 SHALL allow drain and accept in the same cycle; the state stays FULL with the new word, giving 1 word/cycle throughput.
REQ-021 SHALL, while FULL and out_rdy[dst_q]=0, hold out_vld, dst_q and data_q stable and keep in_rdy=0.
REQ-022 SHALL, on accept with in_sel in 5..7:
  - discard the word;
  - leave data_q and dst_q unchanged;
  - pulse err_o high for exactly the next cycle;
  - increment cnt_q by 1.
REQ-023 SHALL, on an illegal accept coinciding with a drain, go to EMPTY next cycle.
REQ-024 SHALL saturate err_cnt at 8'hFF; further drops still pulse err_o but do not wrap the count.
REQ-025 SHALL hold err_o at 0 in any cycle that follows a cycle with no illegal accept.
REQ-026 SHALL treat in_sel, in_data and out_rdy as don't-care whenever in_vld=0 or the block is EMPTY, as applicable.
REQ-027 SHALL hold all state when there is no accept and no drain.

Reset
REQ-028 SHALL, when hresetn=0 at a rising edge, set the following:
  - state=EMPTY, data_q=0, dst_q=0;
  - out_vld=5'b0, err_o=0, err_cnt=0;
  - in_rdy=1 from the first cycle after reset.
REQ-029 SHALL, on reset while FULL, discard the held word; reset has priority over accept and drain in the same cycle.
REQ-030 SHALL have no asynchronous reset paths.

Verification
REQ-031 Bench SHALL cover single transfer (DW=8): in_sel=3, in_data=8'hA5, out_rdy=5'b11111 -> next cycle out_vld=5'b01000, out_data=8'hA5; following cycle out_vld=0.
REQ-032 Bench SHALL cover backpressure: in_sel=1, data 8'h11 accepted, out_rdy=5'b11101 for 4 cycles -> out_vld=5'b00010 held; out_data=8'h11; in_rdy=0 throughout; drain on the cycle out_rdy[1]=1.
REQ-033 Bench SHALL cover streaming: sel 0,1,2,3,4 on consecutive cycles with in_vld=1 and all ready -> out_vld 00001,00010,00100,01000,10000 on consecutive cycles; in_rdy=1 throughout.
REQ-034 Bench SHALL cover illegal index: in_sel=6, in_vld=1 -> out_vld stays 0, err_o=1 for one cycle, err_cnt=1; 300 illegal words -> err_cnt=8'hFF.
REQ-035 Bench SHALL cover reset mid-operation: FULL with dst=2, out_rdy=0, hresetn=0 for one cycle -> next cycle out_vld=0, err_cnt=0, in_rdy=1.
